// File: rtl/count_ctrl_pkg.sv
// Shared types for the count_003 sequencer: timer modes, FSM states and mode resolution.
package count_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_ONESHOT  = 2'd0,
      MODE_PERIODIC = 2'd1,
      MODE_TRIANGLE = 2'd2,
      MODE_RSVD     = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RUN_UP = 3'd2,
      RUN_DN = 3'd3,
      DONE   = 3'd4
   } state_e;

   // Reserved encoding and zero-period repeating modes both degrade to a one-shot.
   function automatic mode_e eff_mode(input logic [1:0] mode, input logic period_zero);
      case (mode)
         2'd1:    return period_zero ? MODE_ONESHOT : MODE_PERIODIC;
         2'd2:    return period_zero ? MODE_ONESHOT : MODE_TRIANGLE;
         default: return MODE_ONESHOT;
      endcase
   endfunction

endpackage

// File: rtl/count_003.sv
// Loadable up/down counter datapath; load has priority over en, one-cycle update latency.
// co flags the terminal count in the current direction while enabled.
module count_003 #(
   parameter int TOP_BIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [TOP_BIT:0] data_in,
   input  logic             updn,
   input  logic             en,
   output logic [TOP_BIT:0] cnt,
   output logic             co
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= data_in;
      end else if (en) begin
         cnt <= updn ? cnt - 1'b1 : cnt + 1'b1;
      end
   end

   assign co = en & (updn ? (cnt == '0) : (cnt == '1));

endmodule

// File: rtl/count_seq_ctrl.sv
// One-shot / periodic / triangle timer sequencer driving a count_003; counter pins combinational from state and cnt_val.
// No backpressure: start sampled only in IDLE, stop aborts at the next edge, hold freezes RUN states; COUNT_SEQ_CTRL_IRQ_EN adds irq/irq_clr.
module count_seq_ctrl
   import count_ctrl_pkg::*;
#(
   parameter int TOP_BIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       cfg_mode,
   input  logic [TOP_BIT:0] cfg_period,
   input  logic             start,
   input  logic             stop,
   input  logic             hold,
   output logic             busy,
   output logic             done,
   output logic             tick,
   output logic             cnt_load,
   output logic [TOP_BIT:0] cnt_data,
   output logic             cnt_updn,
   output logic             cnt_en,
   input  logic [TOP_BIT:0] cnt_val
`ifdef COUNT_SEQ_CTRL_IRQ_EN
   ,
   output logic             irq,
   input  logic             irq_clr
`endif
);

   state_e           r_state;
   state_e           w_state_nxt;
   mode_e            r_mode;
   logic [TOP_BIT:0] r_period;
   logic             w_latch;
   logic             w_cnt_zero;
   logic             w_cnt_top;

   assign w_cnt_zero = (cnt_val == '0);
   assign w_cnt_top  = (cnt_val == r_period);

   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      tick        = 1'b0;
      cnt_load    = 1'b0;
      cnt_data    = '0;
      cnt_updn    = 1'b0;
      cnt_en      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && !stop) begin
               w_latch     = 1'b1;
               w_state_nxt = LOAD;
            end
         end
         LOAD: begin
            busy = 1'b1;
            if (stop) begin
               w_state_nxt = IDLE;
            end else begin
               cnt_load    = 1'b1;
               cnt_data    = (r_mode == MODE_TRIANGLE) ? '0 : r_period;
               w_state_nxt = (r_mode == MODE_TRIANGLE) ? RUN_UP : RUN_DN;
            end
         end
         RUN_DN: begin
            busy = 1'b1;
            if (stop) begin
               w_state_nxt = IDLE;
            end else if (!hold) begin
               if (!w_cnt_zero) begin
                  cnt_en   = 1'b1;
                  cnt_updn = 1'b1;
               end else begin
                  // Bottom of the count: reload, turn around, or finish.
                  case (r_mode)
                     MODE_PERIODIC: begin
                        tick     = 1'b1;
                        cnt_load = 1'b1;
                        cnt_data = r_period;
                     end
                     MODE_TRIANGLE: begin
                        tick        = 1'b1;
                        cnt_en      = 1'b1;
                        w_state_nxt = RUN_UP;
                     end
                     default: w_state_nxt = DONE;
                  endcase
               end
            end
         end
         RUN_UP: begin
            busy = 1'b1;
            if (stop) begin
               w_state_nxt = IDLE;
            end else if (!hold) begin
               cnt_en = 1'b1;
               if (w_cnt_top) begin
                  cnt_updn    = 1'b1;
                  w_state_nxt = RUN_DN;
               end
            end
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_mode   <= MODE_ONESHOT;
         r_period <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_latch) begin
            r_mode   <= eff_mode(cfg_mode, cfg_period == '0);
            r_period <= cfg_period;
         end
      end
   end

`ifdef COUNT_SEQ_CTRL_IRQ_EN
   logic r_irq;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_irq <= 1'b0;
      end else if (done || tick) begin
         r_irq <= 1'b1;
      end else if (irq_clr) begin
         r_irq <= 1'b0;
      end
   end

   assign irq = r_irq;
`endif

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Randomized scoreboard bench for count_seq_ctrl driving a real count_003 instance.
module tb_count_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] cfg_mode;
   logic [4:0] cfg_period;
   logic       start, stop, hold;
   logic       busy, done, tick;
   logic       cnt_load, cnt_updn, cnt_en;
   logic [4:0] cnt_data, cnt_val;
   logic       rst_n, co;
`ifdef COUNT_SEQ_CTRL_IRQ_EN
   logic       irq, irq_clr;
`endif

   assign rst_n = ~rst;

   always #100 clk = ~clk;

   count_seq_ctrl #(.TOP_BIT(4)) dut (
      .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
      .start(start), .stop(stop), .hold(hold),
      .busy(busy), .done(done), .tick(tick),
      .cnt_load(cnt_load), .cnt_data(cnt_data), .cnt_updn(cnt_updn), .cnt_en(cnt_en),
      .cnt_val(cnt_val)
`ifdef COUNT_SEQ_CTRL_IRQ_EN
      , .irq(irq), .irq_clr(irq_clr)
`endif
   );

   count_003 #(.TOP_BIT(4)) u_cnt (
      .clk(clk), .rst_n(rst_n), .load(cnt_load), .data_in(cnt_data),
      .updn(cnt_updn), .en(cnt_en), .cnt(cnt_val), .co(co)
   );

   typedef struct {
      bit         chk_cnt;
      logic [4:0] cnt;
      bit         busy;
      bit         tick;
      bit         done;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input bit chk_cnt, input logic [4:0] c, input bit b, input bit t, input bit d);
      exp_t e;
      e.chk_cnt = chk_cnt; e.cnt = c; e.busy = b; e.tick = t; e.done = d;
      sb.push_back(e);
   endtask

   // Monitor: every cycle the DUT shows activity must match the next expectation.
   always @(negedge clk) begin
      if (!rst && (busy || done || tick)) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_activity: busy=%b tick=%b done=%b cnt=%0d with nothing pending",
                     busy, tick, done, cnt_val);
         end else begin
            mon_e = sb.pop_front();
            if (busy !== mon_e.busy || tick !== mon_e.tick || done !== mon_e.done ||
                (mon_e.chk_cnt && cnt_val !== mon_e.cnt)) begin
               n_bad++;
               $display("FAIL cycle_check at %0t: busy/tick/done/cnt got %b/%b/%b/%0d expected %b/%b/%b/%0d%s",
                        $time, busy, tick, done, cnt_val, mon_e.busy, mon_e.tick, mon_e.done,
                        mon_e.cnt, mon_e.chk_cnt ? "" : "(cnt not checked)");
            end
         end
      end
   end

   // Reference: effective mode and counter value after r un-held run cycles.
   function automatic int eff(input int m, input int p);
      if ((m == 1 || m == 2) && p != 0) return m;
      return 0;
   endfunction

   function automatic logic [4:0] ref_cnt(input int em, input int p, input int r);
      int ph;
      case (em)
         1: return 5'(p - (r % (p + 1)));
         2: begin
            ph = r % (2 * p);
            return 5'((ph <= p) ? ph : 2 * p - ph);
         end
         default: return 5'(p - r);
      endcase
   endfunction

   task automatic run_op(input int mode_in, input int p, input int hold_r, input int hold_n,
                         input int hold_pct, input int stop_at_in, input bit rand_start);
      int         em, r, cyc, held, stop_at;
      bit         h, fin, tk;
      logic [4:0] c;
      em = eff(mode_in, p);
      stop_at = stop_at_in;
      if (em != 0 && stop_at == 0) stop_at = 2 * p + 20;
      @(posedge clk); #1;
      cfg_mode = mode_in[1:0]; cfg_period = p[4:0]; start = 1'b1; stop = 1'b0; hold = 1'b0;
      @(posedge clk); #1;
      start = rand_start ? 1'($urandom_range(1)) : 1'b0;
      cfg_mode = 2'($urandom); cfg_period = 5'($urandom);
      hold = 1'($urandom_range(1));
      push(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      r = 0; cyc = 0; held = 0; fin = 1'b0;
      while (!fin) begin
         @(posedge clk); #1;
         cyc++;
         c = ref_cnt(em, p, r);
         if (rand_start) start = 1'($urandom_range(1));
         h = (r == hold_r && held < hold_n) || ($urandom_range(99) < hold_pct);
         hold = h;
         if ((stop_at != 0 && cyc == stop_at) || cyc >= 300) begin
            stop = 1'b1;
            push(1'b1, c, 1'b1, 1'b0, 1'b0);
            fin = 1'b1;
         end else if (h) begin
            if (r == hold_r) held++;
            push(1'b1, c, 1'b1, 1'b0, 1'b0);
         end else begin
            tk = (em == 1 && c == 0) || (em == 2 && c == 0 && r > 0);
            push(1'b1, c, 1'b1, tk, 1'b0);
            if (em == 0 && r == p) begin
               @(posedge clk); #1;
               if (rand_start) start = 1'($urandom_range(1));
               hold = 1'($urandom_range(1));
               push(1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
               fin = 1'b1;
            end else begin
               r++;
            end
         end
      end
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0; hold = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
      cfg_mode = 2'd0; cfg_period = 5'd0;
`ifdef COUNT_SEQ_CTRL_IRQ_EN
      irq_clr = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_tick", 32'(tick), 0);
      chk("rst_cnt_en", 32'(cnt_en), 0);
      chk("rst_cnt_load", 32'(cnt_load), 0);
      chk("rst_cnt_updn", 32'(cnt_updn), 0);
      chk("rst_cnt_data", 32'(cnt_data), 0);
`ifdef COUNT_SEQ_CTRL_IRQ_EN
      chk("rst_irq", 32'(irq), 0);
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(0, 5, -1, 0, 0, 0, 1'b0);
      run_op(1, 3, -1, 0, 0, 20, 1'b0);
`ifdef COUNT_SEQ_CTRL_IRQ_EN
      chk("irq_after_tick", 32'(irq), 1);
      irq_clr = 1'b1;
      @(posedge clk); #1;
      irq_clr = 1'b0;
      chk("irq_cleared", 32'(irq), 0);
      @(posedge clk); #1;
      chk("irq_stays_clear", 32'(irq), 0);
`endif
      run_op(2, 4, -1, 0, 0, 30, 1'b0);
      run_op(0, 10, 4, 3, 0, 0, 1'b0);
      run_op(0, 0, -1, 0, 0, 0, 1'b0);
      run_op(3, 7, -1, 0, 0, 0, 1'b0);
      run_op(1, 0, -1, 0, 0, 0, 1'b0);
      run_op(2, 1, -1, 0, 0, 12, 1'b0);
      run_op(0, 6, -1, 0, 0, 0, 1'b1);
      run_op(0, 9, -1, 0, 0, 5, 1'b0);

      @(posedge clk); #1;
      start = 1'b1; stop = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      chk("stop_start_idle", 32'(busy), 0);
      @(posedge clk); #1;
      chk("stop_start_idle2", 32'(busy), 0);

      for (int i = 0; i < 30; i++) begin
         int m, p, sa;
         m  = int'($urandom_range(3));
         p  = int'($urandom_range(31));
         sa = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(70, 1));
         run_op(m, p, -1, 0, int'($urandom_range(30)), sa, 1'($urandom_range(1)));
      end

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
